// File: rtl/panel_scan_ctrl.sv
// -----------------------------------------------------------------------------
// panel_scan_ctrl
//
// Row / bit-plane sequencer for a HUB75 LED panel. For each line cycle it
// pulses the line renderer to shift one row at one PWM threshold. It then
// blanks the panel, strobes the latch and drives the new row address. Finally
// it enables the outputs for a fixed on-time. The next row is shifted while the
// current row is on display. PWM threshold is the inner loop and row is the
// outer loop.
//
// Ports
//   clk_25MHz     in   system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   1 = scan; 0 = stop at the next line-cycle boundary
//   render_begin  out  one-cycle start pulse to the line renderer
//   render_done   in   renderer has finished shifting (level)
//   render_addr   out  row being shifted by the renderer
//   render_pwm    out  PWM threshold used by the renderer
//   panel_addr    out  row address driven to the panel (A..E)
//   panel_lat     out  panel latch strobe, active high
//   panel_oe_n    out  panel output enable, active low
//   frame_done    out  one-cycle pulse after the last row/threshold is latched
// -----------------------------------------------------------------------------
module panel_scan_ctrl #(
   parameter int ROWS         = 32,
   parameter int PWM_LEVELS   = 16,
   parameter int ON_CYCLES    = 64,
   parameter int BLANK_CYCLES = 2,
   parameter int LATCH_CYCLES = 1
) (
   input  logic       clk_25MHz,
   input  logic       rst_n,
   input  logic       enable,
   output logic       render_begin,
   input  logic       render_done,
   output logic [4:0] render_addr,
   output logic [3:0] render_pwm,
   output logic [4:0] panel_addr,
   output logic       panel_lat,
   output logic       panel_oe_n,
   output logic       frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_BLANK,
      S_LATCH
   } state_e;

   localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
   localparam logic [3:0] PWM_MAX = 4'(PWM_LEVELS - 1);

   state_e      state_q, state_d;
   logic [3:0]  phase_q, phase_d;        // BLANK / LATCH cycles remaining - 1
   logic [9:0]  timer_q, timer_d;        // display on-time remaining
   logic        first_wait_q, first_wait_d;
   logic [4:0]  raddr_q, raddr_d;
   logic [3:0]  pwm_q, pwm_d;
   logic [4:0]  paddr_q, paddr_d;
   logic        begin_q, begin_d;
   logic        lat_q, lat_d;
   logic        oe_n_q, oe_n_d;
   logic        frame_q, frame_d;

   // NOTE: every signal gets a default before the case statement so that no
   // path leaves it unassigned; otherwise a latch would be inferred.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      first_wait_d = 1'b0;
      timer_d      = (timer_q != '0) ? timer_q - 10'd1 : '0;
      raddr_d      = raddr_q;
      pwm_d        = pwm_q;
      paddr_d      = paddr_q;
      frame_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_START;
         end
         S_START: begin
            state_d      = S_WAIT;
            first_wait_d = 1'b1;
         end
         S_WAIT: begin
            // The renderer's done level is stale until it has seen the begin
            // pulse, so the first WAIT cycle never exits.
            if (!first_wait_q && render_done && (timer_q == '0)) begin
               state_d = S_BLANK;
               phase_d = 4'(BLANK_CYCLES - 1);
               paddr_d = raddr_q;
            end
         end
         S_BLANK: begin
            if (phase_q == '0) begin
               state_d = S_LATCH;
               phase_d = 4'(LATCH_CYCLES - 1);
            end else begin
               phase_d = phase_q - 4'd1;
            end
         end
         S_LATCH: begin
            if (phase_q == '0) begin
               if (pwm_q == PWM_MAX) begin
                  pwm_d = '0;
                  if (raddr_q == ROW_MAX) begin
                     raddr_d = '0;
                     frame_d = 1'b1;
                  end else begin
                     raddr_d = raddr_q + 5'd1;
                  end
               end else begin
                  pwm_d = pwm_q + 4'd1;
               end
               if (enable) begin
                  state_d = S_START;
                  timer_d = 10'(ON_CYCLES);
               end else begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end
            end else begin
               phase_d = phase_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so that, once registered, they
   // line up exactly with the state they belong to.
   always_comb begin
      begin_d = (state_d == S_START);
      lat_d   = (state_d == S_LATCH);
      oe_n_d  = (state_d inside {S_IDLE, S_BLANK, S_LATCH}) || (timer_d == '0);
   end

   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         phase_q      <= '0;
         timer_q      <= '0;
         first_wait_q <= 1'b0;
         raddr_q      <= '0;
         pwm_q        <= '0;
         paddr_q      <= '0;
         begin_q      <= 1'b0;
         lat_q        <= 1'b0;
         oe_n_q       <= 1'b1;
         frame_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         timer_q      <= timer_d;
         first_wait_q <= first_wait_d;
         raddr_q      <= raddr_d;
         pwm_q        <= pwm_d;
         paddr_q      <= paddr_d;
         begin_q      <= begin_d;
         lat_q        <= lat_d;
         oe_n_q       <= oe_n_d;
         frame_q      <= frame_d;
      end
   end

   assign render_begin = begin_q;
   assign render_addr  = raddr_q;
   assign render_pwm   = pwm_q;
   assign panel_addr   = paddr_q;
   assign panel_lat    = lat_q;
   assign panel_oe_n   = oe_n_q;
   assign frame_done   = frame_q;

endmodule
